// File: rtl/sound_pkg.sv
// Shared definitions for the pong sound sequencer.
// Holds the event encoding, the sequencer state type, the constant
// 4x8 melody table and a fixed-priority grant helper.
package sound_pkg;

  localparam int HP_W = 15;

  // Event encoding, also used as the row index of the note table
  localparam logic [1:0] EV_LFT   = 2'd0;
  localparam logic [1:0] EV_RGT   = 2'd1;
  localparam logic [1:0] EV_SCORE = 2'd2;
  localparam logic [1:0] EV_OVER  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  typedef logic [HP_W-1:0] note_t;

  // Half-periods in clk cycles; 0 is a rest
  localparam note_t NOTE_TABLE [4][8] = '{
    '{15'd6074,  15'd5733,  15'd5108, 15'd4551, 15'd4295,  15'd3826,  15'd3409, 15'd0},
    '{15'd3409,  15'd3826,  15'd4295, 15'd4551, 15'd5108,  15'd5733,  15'd6074, 15'd0},
    '{15'd4551,  15'd0,     15'd4551, 15'd0,    15'd3038,  15'd3038,  15'd0,    15'd0},
    '{15'd11468, 15'd10215, 15'd9102, 15'd0,    15'd11468, 15'd10215, 15'd9102, 15'd0}
  };

  // Fixed priority: over > score > rgt > lft
  function automatic logic [1:0] pick_event(input logic [3:0] req);
    logic [1:0] ev;
    if (req[3]) begin
      ev = EV_OVER;
    end else if (req[2]) begin
      ev = EV_SCORE;
    end else if (req[1]) begin
      ev = EV_RGT;
    end else begin
      ev = EV_LFT;
    end
    return ev;
  endfunction

endpackage

// File: rtl/sound_sequencer_tone_gen.sv
// Square-wave tone generator driving the speaker pin.
// Ports:
//   clk_6MHz    - clock
//   reset       - asynchronous active-low reset
//   note_load   - new note strobe; restarts the divider, keeps speaker phase
//   half_period - half-period in clk cycles, 0 silences the output
//   speaker     - square-wave output
module tone_gen
  import sound_pkg::*;
(
  input  logic            clk_6MHz,
  input  logic            reset,
  input  logic            note_load,
  input  logic [HP_W-1:0] half_period,
  output logic            speaker
);

  logic [HP_W-1:0] divider_r;
  logic            speaker_r;

  // Divider and speaker flip-flop; a silent note forces both to zero
  always_ff @(posedge clk_6MHz or negedge reset) begin
    if (!reset) begin
      divider_r <= 15'd0;
      speaker_r <= 1'b0;
    end else if (half_period == 15'd0) begin
      divider_r <= 15'd0;
      speaker_r <= 1'b0;
    end else if (note_load) begin
      divider_r <= 15'd0;
    end else if (divider_r >= (half_period - 15'd1)) begin
      // >= also recovers if a shorter note arrives mid-count
      divider_r <= 15'd0;
      speaker_r <= ~speaker_r;
    end else begin
      divider_r <= divider_r + 15'd1;
    end
  end

  assign speaker = speaker_r;

endmodule

// File: rtl/sound_sequencer.sv
// Game sound sequencer: latches four event requests, grants them one at a
// time by fixed priority and plays an 8-note melody per event through the
// tone generator. A game-over request aborts any other melody.
// Ports:
//   clk_6MHz    - clock
//   reset       - asynchronous active-low reset
//   ev_lft/ev_rgt/ev_score/ev_over - event requests, rising-edge detected
//   busy        - high while an event is being sequenced
//   cur_event   - granted event (0 lft, 1 rgt, 2 score, 3 over), held when idle
//   half_period - current note half-period in clk cycles, 0 = silence
//   speaker     - square-wave output
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int TICK_DIV = 600000
)(
  input  logic            clk_6MHz,
  input  logic            reset,
  input  logic            ev_lft,
  input  logic            ev_rgt,
  input  logic            ev_score,
  input  logic            ev_over,
  output logic            busy,
  output logic [1:0]      cur_event,
  output logic [HP_W-1:0] half_period,
  output logic            speaker
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  logic [3:0]      ev_s, ev_d_r, edge_s, pend_r, pend_s;
  state_t          state_r, state_s;
  logic [1:0]      cur_event_r, cur_event_s, grant_s;
  logic [2:0]      step_r, step_s;
  logic [PW-1:0]   presc_r, presc_s;
  logic [HP_W-1:0] hp_r, hp_s;
  logic            busy_r, tick_s, preempt_s, note_load_s;

  assign ev_s      = {ev_over, ev_score, ev_rgt, ev_lft};
  assign edge_s    = ev_s & ~ev_d_r;
  assign tick_s    = (presc_r == TICK_LAST);
  assign grant_s   = pick_event(pend_r);
  // Over aborts anything else; during its own playback it only queues a replay
  assign preempt_s = pend_r[3] && (cur_event_r != EV_OVER) && (state_r != ST_IDLE);

  // Next-state, grant and datapath update logic
  always_comb begin
    state_s     = state_r;
    cur_event_s = cur_event_r;
    step_s      = step_r;
    pend_s      = pend_r | edge_s;
    presc_s     = presc_r;
    hp_s        = hp_r;
    note_load_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        presc_s = '0;
        if (pend_r != 4'b0000) begin
          state_s     = ST_LOAD;
          cur_event_s = grant_s;
          step_s      = 3'd0;
          pend_s      = (pend_r & ~(4'b0001 << grant_s)) | edge_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        hp_s        = NOTE_TABLE[cur_event_r][step_r];
        presc_s     = '0;
        note_load_s = 1'b1;
        state_s     = ST_PLAY;
      end
      ST_PLAY: begin
        if (tick_s) begin
          presc_s = '0;
          if (step_r != 3'd7) begin
            step_s  = step_r + 3'd1;
            state_s = ST_LOAD;
          end else begin
            hp_s    = 15'd0;
            state_s = ST_GAP;
          end
        end else begin
          presc_s = presc_r + PW'(1);
        end
      end
      ST_GAP: begin
        if (tick_s) begin
          presc_s = '0;
          state_s = ST_IDLE;
        end else begin
          presc_s = presc_r + PW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        presc_s = '0;
      end
    endcase

    // Preemption overrides the normal flow and drops every queued request
    if (preempt_s) begin
      state_s     = ST_LOAD;
      cur_event_s = EV_OVER;
      step_s      = 3'd0;
      presc_s     = '0;
      pend_s      = edge_s;
    end else begin
      pend_s = pend_s;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_6MHz or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      ev_d_r      <= 4'b0000;
      pend_r      <= 4'b0000;
      cur_event_r <= 2'd0;
      step_r      <= 3'd0;
      presc_r     <= '0;
      hp_r        <= 15'd0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      ev_d_r      <= ev_s;
      pend_r      <= pend_s;
      cur_event_r <= cur_event_s;
      step_r      <= step_s;
      presc_r     <= presc_s;
      hp_r        <= hp_s;
      busy_r      <= (state_s != ST_IDLE);
    end
  end

  tone_gen u_tone_gen (
    .clk_6MHz    (clk_6MHz),
    .reset       (reset),
    .note_load   (note_load_s),
    .half_period (hp_r),
    .speaker     (speaker)
  );

  assign busy        = busy_r;
  assign cur_event   = cur_event_r;
  assign half_period = hp_r;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer. Instance a (short notes) runs a vector
// table of playback, priority, preemption and replay scenarios; instance b
// (long notes) checks speaker timing and asynchronous reset mid-note.
module tb_sound_sequencer;

  logic clk;
  logic reset;
  logic ev_lft_a, ev_rgt_a, ev_score_a, ev_over_a;
  logic busy_a, spk_a;
  logic [1:0] cur_a;
  logic [14:0] hp_a;
  logic ev_lft_b, ev_rgt_b, ev_score_b, ev_over_b;
  logic busy_b, spk_b;
  logic [1:0] cur_b;
  logic [14:0] hp_b;

  int n_err = 0;
  int n_chk = 0;

  sound_sequencer #(.TICK_DIV(20)) dut_a (
    .clk_6MHz(clk), .reset(reset),
    .ev_lft(ev_lft_a), .ev_rgt(ev_rgt_a), .ev_score(ev_score_a), .ev_over(ev_over_a),
    .busy(busy_a), .cur_event(cur_a), .half_period(hp_a), .speaker(spk_a)
  );

  sound_sequencer #(.TICK_DIV(12200)) dut_b (
    .clk_6MHz(clk), .reset(reset),
    .ev_lft(ev_lft_b), .ev_rgt(ev_rgt_b), .ev_score(ev_score_b), .ev_over(ev_over_b),
    .busy(busy_b), .cur_event(cur_b), .half_period(hp_b), .speaker(spk_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ev;      // {over, score, rgt, lft} applied before waiting
    int          wait_n;  // clock edges to advance before comparing
    logic        busy;
    logic [1:0]  cur;
    logic [14:0] hp;
    logic        spk;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] ev, input int w, input logic b,
                     input logic [1:0] c, input logic [14:0] h, input logic s);
    vec_t v;
    v.ev = ev; v.wait_n = w; v.busy = b; v.cur = c; v.hp = h; v.spk = s;
    vecs.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    {ev_over_a, ev_score_a, ev_rgt_a, ev_lft_a} = 4'b0000;
    {ev_over_b, ev_score_b, ev_rgt_b, ev_lft_b} = 4'b0000;

    // lft melody step by step, busy falls 190 cycles after the request edge
    add(4'b0001, 1, 0, 0, 0, 0);
    add(4'b0000, 1, 1, 0, 0, 0);
    add(4'b0000, 1, 1, 0, 6074, 0);
    add(4'b0000, 21, 1, 0, 5733, 0);
    add(4'b0000, 21, 1, 0, 5108, 0);
    add(4'b0000, 21, 1, 0, 4551, 0);
    add(4'b0000, 21, 1, 0, 4295, 0);
    add(4'b0000, 21, 1, 0, 3826, 0);
    add(4'b0000, 21, 1, 0, 3409, 0);
    add(4'b0000, 21, 1, 0, 0, 0);
    add(4'b0000, 39, 1, 0, 0, 0);
    add(4'b0000, 1, 0, 0, 0, 0);
    // lft+rgt together: rgt first, one idle cycle, then lft
    add(4'b0011, 1, 0, 0, 0, 0);
    add(4'b0000, 1, 1, 1, 0, 0);
    add(4'b0000, 1, 1, 1, 3409, 0);
    add(4'b0000, 21, 1, 1, 3826, 0);
    add(4'b0000, 165, 1, 1, 0, 0);
    add(4'b0000, 1, 0, 1, 0, 0);
    add(4'b0000, 1, 1, 0, 0, 0);
    add(4'b0000, 1, 1, 0, 6074, 0);
    add(4'b0000, 186, 1, 0, 0, 0);
    add(4'b0000, 1, 0, 0, 0, 0);
    // score with rest note, then over preempts at step 3 and drops lft/rgt
    add(4'b0100, 1, 0, 0, 0, 0);
    add(4'b0000, 1, 1, 2, 0, 0);
    add(4'b0000, 1, 1, 2, 4551, 0);
    add(4'b0000, 21, 1, 2, 0, 0);
    add(4'b0000, 5, 1, 2, 0, 0);
    add(4'b0000, 5, 1, 2, 0, 0);
    add(4'b0000, 5, 1, 2, 0, 0);
    add(4'b0000, 6, 1, 2, 4551, 0);
    add(4'b0000, 21, 1, 2, 0, 0);
    add(4'b0000, 5, 1, 2, 0, 0);
    add(4'b0011, 1, 1, 2, 0, 0);
    add(4'b0000, 1, 1, 2, 0, 0);
    add(4'b1000, 1, 1, 2, 0, 0);
    add(4'b0000, 1, 1, 3, 0, 0);
    add(4'b0000, 1, 1, 3, 11468, 0);
    add(4'b0000, 21, 1, 3, 10215, 0);
    add(4'b0000, 165, 1, 3, 0, 0);
    add(4'b0000, 1, 0, 3, 0, 0);
    add(4'b0000, 10, 0, 3, 0, 0);
    // over during over playback: no abort, one replay afterwards
    add(4'b1000, 1, 0, 3, 0, 0);
    add(4'b0000, 1, 1, 3, 0, 0);
    add(4'b0000, 1, 1, 3, 11468, 0);
    add(4'b0000, 30, 1, 3, 10215, 0);
    add(4'b1000, 1, 1, 3, 10215, 0);
    add(4'b0000, 1, 1, 3, 10215, 0);
    add(4'b0000, 154, 1, 3, 0, 0);
    add(4'b0000, 1, 0, 3, 0, 0);
    add(4'b0000, 1, 1, 3, 0, 0);
    add(4'b0000, 1, 1, 3, 11468, 0);
    add(4'b0000, 186, 1, 3, 0, 0);
    add(4'b0000, 1, 0, 3, 0, 0);
    add(4'b0000, 5, 0, 3, 0, 0);
    // lft held high plays once; one fresh edge during playback replays once
    add(4'b0001, 1, 0, 3, 0, 0);
    add(4'b0001, 1, 1, 0, 0, 0);
    add(4'b0001, 1, 1, 0, 6074, 0);
    add(4'b0001, 105, 1, 0, 3826, 0);
    add(4'b0000, 2, 1, 0, 3826, 0);
    add(4'b0001, 2, 1, 0, 3826, 0);
    add(4'b0000, 77, 1, 0, 0, 0);
    add(4'b0000, 1, 0, 0, 0, 0);
    add(4'b0000, 1, 1, 0, 0, 0);
    add(4'b0000, 1, 1, 0, 6074, 0);
    add(4'b0000, 186, 1, 0, 0, 0);
    add(4'b0000, 1, 0, 0, 0, 0);
    add(4'b0000, 5, 0, 0, 0, 0);

    step(2);
    check("reset_busy_a", busy_a, 0);
    check("reset_hp_a", hp_a, 0);
    check("reset_spk_b", spk_b, 0);
    reset = 1'b1;
    step(3);
    check("idle_after_reset", {busy_a, cur_a, hp_a, spk_a}, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      {ev_over_a, ev_score_a, ev_rgt_a, ev_lft_a} = vecs[i].ev;
      step(vecs[i].wait_n);
      n_chk++;
      if ({busy_a, cur_a, hp_a, spk_a} !==
          {vecs[i].busy, vecs[i].cur, vecs[i].hp, vecs[i].spk}) begin
        n_err++;
        $display("FAIL vec%0d: got busy=%0d cur=%0d hp=%0d spk=%0d, expected busy=%0d cur=%0d hp=%0d spk=%0d",
                 i, busy_a, cur_a, hp_a, spk_a,
                 vecs[i].busy, vecs[i].cur, vecs[i].hp, vecs[i].spk);
      end
    end

    // Speaker timing on long notes: toggles at 6074 and 12148 after PLAY entry
    ev_lft_b = 1'b1;
    step(1);
    ev_lft_b = 1'b0;
    step(1);
    check("b_busy_rise", busy_b, 1);
    step(1);
    check("b_hp_note0", hp_b, 6074);
    check("b_spk_start", spk_b, 0);
    step(6073);
    check("b_spk_before_t1", spk_b, 0);
    step(1);
    check("b_spk_t1", spk_b, 1);
    step(6073);
    check("b_spk_before_t2", spk_b, 1);
    step(1);
    check("b_spk_t2", spk_b, 0);
    step(5785);
    check("b_spk_before_note1_t1", spk_b, 0);
    step(1);
    check("b_spk_note1_t1", spk_b, 1);
    check("b_hp_note1", hp_b, 5733);
    step(100);

    // Asynchronous reset mid-note with speaker high
    reset = 1'b0;
    #1;
    check("b_async_reset_busy", busy_b, 0);
    check("b_async_reset_hp", hp_b, 0);
    check("b_async_reset_spk", spk_b, 0);
    step(2);
    reset = 1'b1;
    step(10);
    check("b_idle_after_release", {busy_b, cur_b, hp_b, spk_b}, 0);
    check("a_idle_after_release", busy_a, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
